// File: rtl/gate_unit.sv
// Registered N_IN-operand bitwise gate with a 2-entry {op, y} output FIFO and valid/ready on both sides.
// Optional macro GATE_UNIT_CNT_EN adds a 16-bit completed-pop counter on out_count.
module gate_unit #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_y,
  output logic [2:0]            out_op
`ifdef GATE_UNIT_CNT_EN
  ,
  output logic [15:0]           out_count
`endif
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;

  // Reductions seed from operand0 so N_IN=1 collapses to operand0 / ~operand0.
  function automatic logic [WIDTH-1:0] gate_reduce(input logic [2:0] op,
                                                   input logic [N_IN*WIDTH-1:0] d);
    logic [WIDTH-1:0] opd0;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] res;
    opd0  = d[WIDTH-1:0];
    and_r = opd0;
    or_r  = opd0;
    xor_r = opd0;
    for (int i = 1; i < N_IN; i++) begin
      and_r = and_r & d[i*WIDTH +: WIDTH];
      or_r  = or_r  | d[i*WIDTH +: WIDTH];
      xor_r = xor_r ^ d[i*WIDTH +: WIDTH];
    end
    case (op)
      OP_AND:  res = and_r;
      OP_OR:   res = or_r;
      OP_XOR:  res = xor_r;
      OP_NAND: res = ~and_r;
      OP_NOR:  res = ~or_r;
      OP_XNOR: res = ~xor_r;
      OP_NOT:  res = ~opd0;
      default: res = opd0;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] y_p0;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] y_mem  [2];
  logic [2:0]       op_mem [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;

  assign y_p0      = gate_reduce(in_op, in_data);
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_y     = y_mem[rd_ptr];
  assign out_op    = op_mem[rd_ptr];

  // Stage p0 -> FIFO: result is captured at the accepting edge, never bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        y_mem[k]  <= '0;
        op_mem[k] <= '0;
      end
    end else begin
      if (push) begin
        y_mem[wr_ptr]  <= y_p0;
        op_mem[wr_ptr] <= in_op;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef GATE_UNIT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= 16'd0;
    end else if (pop) begin
      out_count <= out_count + 16'd1;
    end
  end
`endif

endmodule
